// File: rtl/status_led_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// status_led_ctrl : per-LED RGB driver (status / activity / manual / off) with
// shared PWM dimming, blink timing and a sticky overflow flag.   Rev 1.0
// ----------------------------------------------------------------------------
module status_led_ctrl #(
  parameter int NUM_LEDS    = 2,
  parameter int PWM_BITS    = 8,
  parameter int BLINK_DIV   = 25000000,
  parameter int HOLD_CYCLES = 5000000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  status_enabled_i,
  input  logic                  status_triggered_i,
  input  logic                  status_overflow_i,
  input  logic                  clear_i,
  input  logic [NUM_LEDS-1:0]   activity_i,
  input  logic [2*NUM_LEDS-1:0] cfg_mode_i,
  input  logic [3*NUM_LEDS-1:0] cfg_rgb_i,
  input  logic [PWM_BITS-1:0]   cfg_brightness_i,
  output logic [3*NUM_LEDS-1:0] led_rgb_o,
  output logic                  overflow_sticky_o
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [BLINK_W-1:0] c_BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HOLD_W-1:0]  c_HOLD_LOAD  = HOLD_W'(HOLD_CYCLES);

  localparam logic [1:0] c_MODE_OFF    = 2'd0;
  localparam logic [1:0] c_MODE_STATUS = 2'd1;
  localparam logic [1:0] c_MODE_ACT    = 2'd2;
  localparam logic [1:0] c_MODE_MANUAL = 2'd3;

  localparam logic [2:0] c_COL_RED   = 3'b100;
  localparam logic [2:0] c_COL_GREEN = 3'b010;
  localparam logic [2:0] c_COL_BLUE  = 3'b001;

  logic                r_overflow_sticky;
  logic [2:0]          r_status_rgb;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_on;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_pwm_on;

  // The colour priority looks at the sticky flag before this edge's update,
  // so a fresh overflow pulse still wins through status_overflow_i directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow_sticky <= 1'b0;
      r_status_rgb      <= 3'b000;
    end else begin
      if (status_overflow_i) begin
        r_overflow_sticky <= 1'b1;
      end else if (clear_i) begin
        r_overflow_sticky <= 1'b0;
      end

      if (r_overflow_sticky || status_overflow_i) begin
        r_status_rgb <= c_COL_RED;
      end else if (status_triggered_i) begin
        r_status_rgb <= c_COL_GREEN;
      end else if (status_enabled_i) begin
        r_status_rgb <= c_COL_BLUE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_pwm_cnt   <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (r_blink_cnt == c_BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign w_pwm_on          = (&cfg_brightness_i) || (r_pwm_cnt < cfg_brightness_i);
  assign overflow_sticky_o = r_overflow_sticky;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      logic [HOLD_W-1:0] r_stretch;
      logic [2:0]        r_led;
      logic [2:0]        w_color;
      logic [1:0]        w_mode;
      logic [2:0]        w_rgb;

      assign w_mode = cfg_mode_i[2*gi +: 2];
      assign w_rgb  = cfg_rgb_i[3*gi +: 3];

      always_comb begin
        w_color = 3'b000;
        case (w_mode)
          c_MODE_OFF:    w_color = 3'b000;
          c_MODE_STATUS: w_color = {r_status_rgb[2] & r_blink_on, r_status_rgb[1:0]};
          c_MODE_ACT:    w_color = (r_stretch != '0) ? w_rgb : 3'b000;
          c_MODE_MANUAL: w_color = w_rgb;
          default:       w_color = 3'b000;
        endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_stretch <= '0;
          r_led     <= 3'b000;
        end else begin
          if (activity_i[gi]) begin
            r_stretch <= c_HOLD_LOAD;
          end else if (r_stretch != '0) begin
            r_stretch <= r_stretch - HOLD_W'(1);
          end
          r_led <= w_color & {3{w_pwm_on}};
        end
      end

      assign led_rgb_o[3*gi +: 3] = r_led;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_status_led_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_status_led_ctrl : randomized bench for status_led_ctrl against a
// timeline-based reference model.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_status_led_ctrl;

  localparam int N  = 2;
  localparam int PB = 4;
  localparam int BD = 4;
  localparam int HC = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en, trig, ovf, clr;
  logic [N-1:0]    act;
  logic [2*N-1:0]  cfg_mode;
  logic [3*N-1:0]  cfg_rgb;
  logic [PB-1:0]   cfg_bright;
  logic [3*N-1:0]  led;
  logic            sticky;

  status_led_ctrl #(
    .NUM_LEDS(N), .PWM_BITS(PB), .BLINK_DIV(BD), .HOLD_CYCLES(HC)
  ) u_dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .status_enabled_i   (en),
    .status_triggered_i (trig),
    .status_overflow_i  (ovf),
    .clear_i            (clr),
    .activity_i         (act),
    .cfg_mode_i         (cfg_mode),
    .cfg_rgb_i          (cfg_rgb),
    .cfg_brightness_i   (cfg_bright),
    .led_rgb_o          (led),
    .overflow_sticky_o  (sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: edges since reset release, sticky flag, status colour,
  // and the edge index of each LED's most recent activity pulse.
  int         m_edges;
  bit         m_sticky;
  logic [2:0] m_scol;
  int         m_last_act [N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, m_edges);
  endtask

  task automatic model_reset();
    m_edges  = 0;
    m_sticky = 1'b0;
    m_scol   = 3'b000;
    for (int i = 0; i < N; i++) m_last_act[i] = -1000;
  endtask

  function automatic logic [3*N-1:0] model_led();
    logic [3*N-1:0] r;
    bit             phase_on;
    bit             pwm_on;
    logic [1:0]     mode;
    logic [2:0]     rgb, col;
    r        = '0;
    phase_on = ((m_edges / BD) % 2) == 0;
    pwm_on   = (cfg_bright == {PB{1'b1}}) || ((m_edges % (2**PB)) < int'(cfg_bright));
    for (int i = 0; i < N; i++) begin
      mode = cfg_mode[2*i +: 2];
      rgb  = cfg_rgb[3*i +: 3];
      case (mode)
        2'd1:    col = {m_scol[2] & phase_on, m_scol[1:0]};
        2'd2:    col = ((m_edges - m_last_act[i]) < HC) ? rgb : 3'b000;
        2'd3:    col = rgb;
        default: col = 3'b000;
      endcase
      r[3*i +: 3] = pwm_on ? col : 3'b000;
    end
    return r;
  endfunction

  // Drive one cycle of inputs (called just after a falling edge), then
  // check the outputs shortly after the following rising edge.
  task automatic cycle(input logic i_en, input logic i_trig, input logic i_ovf,
                       input logic i_clr, input logic [N-1:0] i_act);
    logic [3*N-1:0] exp_led;
    en = i_en; trig = i_trig; ovf = i_ovf; clr = i_clr; act = i_act;
    @(posedge clk);
    exp_led = model_led();
    if (m_sticky || i_ovf)  m_scol = 3'b100;
    else if (i_trig)        m_scol = 3'b010;
    else if (i_en)          m_scol = 3'b001;
    if (i_ovf)              m_sticky = 1'b1;
    else if (i_clr)         m_sticky = 1'b0;
    for (int i = 0; i < N; i++) if (i_act[i]) m_last_act[i] = m_edges + 1;
    m_edges++;
    #1;
    check_eq("led_rgb", 32'(led), 32'(exp_led));
    check_eq("overflow_sticky", 32'(sticky), 32'(m_sticky));
    @(negedge clk);
  endtask

  task automatic random_cfg();
    cfg_mode = 2*N'($urandom);
    cfg_rgb  = 3*N'($urandom);
    case ($urandom_range(0, 3))
      0:       cfg_bright = '0;
      1:       cfg_bright = PB'(4);
      2:       cfg_bright = '1;
      default: cfg_bright = PB'($urandom_range(0, 2**PB - 1));
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    en = 0; trig = 0; ovf = 0; clr = 0; act = '0;
    cfg_mode = '0; cfg_rgb = '0; cfg_bright = '1;
    model_reset();
    #1;
    check_eq("reset_led", 32'(led), 32'd0);
    check_eq("reset_sticky", 32'(sticky), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cfg_mode = {2'd1, 2'd1};
    repeat (4) cycle(0, 0, 0, 0, '0);

    // Priority and hold
    cycle(1, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, '0);
    repeat (3) cycle(0, 0, 0, 0, '0);
    cycle(1, 1, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);

    // Sticky overflow, blink, clear precedence
    cycle(0, 0, 1, 0, '0);
    repeat (10) cycle(0, 0, 0, 0, '0);
    cycle(1, 1, 0, 0, '0);
    cycle(0, 0, 1, 1, '0);
    cycle(0, 0, 0, 0, '0);
    cycle(0, 1, 0, 1, '0);
    repeat (3) cycle(0, 1, 0, 0, '0);

    // Activity stretch with retrigger
    cfg_mode = {2'd2, 2'd2}; cfg_rgb = {3'b011, 3'b110};
    cycle(0, 0, 0, 0, 2'b01);
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 2'b11);
    repeat (6) cycle(0, 0, 0, 0, '0);

    // PWM duties and mixed modes
    cfg_mode = {2'd3, 2'd3}; cfg_rgb = '1;
    foreach (cfg_bright[b]) begin end
    cfg_bright = PB'(4); repeat (16) cycle(0, 0, 0, 0, '0);
    cfg_bright = '0;     repeat (16) cycle(0, 0, 0, 0, '0);
    cfg_bright = '1;     repeat (16) cycle(0, 0, 0, 0, '0);
    cfg_mode = {2'd3, 2'd0}; cfg_rgb = {3'b101, 3'b111};
    repeat (2) cycle(0, 0, 0, 0, '0);

    // Randomized phases
    for (int p = 0; p < 10; p++) begin
      random_cfg();
      for (int c = 0; c < 120; c++) begin
        cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
              N'($urandom_range(0, 2**N - 1) & ($urandom_range(0, 3) == 0 ? '1 : '0)));
      end
    end

    // Asynchronous reset mid-run, checked before the next rising edge
    cfg_mode = {2'd3, 2'd3}; cfg_rgb = '1; cfg_bright = '1;
    cycle(0, 0, 1, 0, '0);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_led", 32'(led), 32'd0);
    check_eq("async_reset_sticky", 32'(sticky), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cfg_mode = {2'd1, 2'd1};
    repeat (3) cycle(0, 0, 0, 0, '0);
    for (int c = 0; c < 200; c++) begin
      if (c % 50 == 0) random_cfg();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 20) == 0, $urandom_range(0, 2) == 0,
            N'($urandom_range(0, 2**N - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
